// File: rtl/rf_pkg.sv
// Shared defaults and types for the multi-port register file.
package rf_pkg;

  localparam int RF_ADDR   = 5;
  localparam int RF_BUS_W  = 32;
  localparam int RF_NUM_RD = 2;
  localparam int RF_NUM_WR = 1;

  typedef logic [RF_ADDR-1:0]  reg_addr_t;
  typedef logic [RF_BUS_W-1:0] reg_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard: one busy bit per register, reserve/clear priority,
// registered popcount and per-read-port busy lookup.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR     = RF_ADDR,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int NUM_WR   = RF_NUM_WR,
  parameter int ZERO_REG = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rsv_en,
  input  logic [ADDR-1:0]              rsv_addr,
  input  logic [NUM_WR-1:0]            clr_en,
  input  logic [NUM_WR-1:0][ADDR-1:0]  clr_addr,
  input  logic [NUM_RD-1:0][ADDR-1:0]  look_addr,
  output logic [NUM_RD-1:0]            look_busy,
  output logic [ADDR:0]                busy_cnt
);

  localparam int DEPTH = 1 << ADDR;

  typedef logic [ADDR:0] cnt_t;

  logic [DEPTH-1:0] busy_q, busy_d;
  cnt_t             cnt_q, cnt_d;

  // Next busy vector: writes retire producers first, then a reservation
  // re-marks its register so a new producer always wins over a retiring one.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (clr_en[w]) begin
        busy_d[clr_addr[w]] = 1'b0;
      end
    end
    if (rsv_en && !(ZERO_REG != 0 && rsv_addr == '0)) begin
      busy_d[rsv_addr] = 1'b1;
    end
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + cnt_t'(busy_d[i]);
    end
  end

  // Busy bits and their count share one edge so the count never lags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : look_g
      assign look_busy[gi] = busy_q[look_addr[gi]];
    end
  endgenerate

  assign busy_cnt = cnt_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_WR synchronous write ports (highest index
// wins on collision), NUM_RD combinational read ports with optional
// same-cycle bypass, optional hardwired-zero r0 and a busy scoreboard.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int ADDR     = RF_ADDR,
  parameter int BUS_W    = RF_BUS_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int NUM_WR   = RF_NUM_WR,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_WR-1:0]             r_write,
  input  logic [NUM_WR-1:0][ADDR-1:0]   rd_addr,
  input  logic [NUM_WR-1:0][BUS_W-1:0]  rd_w_data,
  input  logic [NUM_RD-1:0][ADDR-1:0]   rs_addr,
  output logic [NUM_RD-1:0][BUS_W-1:0]  rs_data,
  output logic [NUM_RD-1:0]             rs_busy,
  input  logic                          rsv_en,
  input  logic [ADDR-1:0]               rsv_addr,
  output logic [ADDR:0]                 busy_cnt
);

  localparam int DEPTH = 1 << ADDR;

  logic [DEPTH-1:0][BUS_W-1:0] regs;
  logic [NUM_RD-1:0]           look_busy;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : reg_g
      logic             we_d;
      logic [BUS_W-1:0] wdata_d;
      logic [BUS_W-1:0] val_q;

      // Write-port priority: later (higher-index) ports override earlier ones.
      always_comb begin
        we_d    = 1'b0;
        wdata_d = val_q;
        for (int w = 0; w < NUM_WR; w++) begin
          if (r_write[w] && rd_addr[w] == ADDR'(gi)) begin
            we_d    = 1'b1;
            wdata_d = rd_w_data[w];
          end
        end
      end

      // Storage element; r0 stays at zero when hardwired.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          val_q <= '0;
        end else if (we_d && !(ZERO_REG != 0 && gi == 0)) begin
          val_q <= wdata_d;
        end
      end

      assign regs[gi] = val_q;
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : rd_g
      logic             hit_d;
      logic [BUS_W-1:0] byp_d;
      logic [BUS_W-1:0] data_d;
      logic             busy_d;

      // Read mux: stored value, overridden by bypass, overridden by zero/reset.
      always_comb begin
        hit_d = 1'b0;
        byp_d = '0;
        for (int w = 0; w < NUM_WR; w++) begin
          if (r_write[w] && rd_addr[w] == rs_addr[gi]) begin
            hit_d = 1'b1;
            byp_d = rd_w_data[w];
          end
        end
        data_d = regs[rs_addr[gi]];
        busy_d = look_busy[gi];
        if (BYPASS != 0 && hit_d) begin
          data_d = byp_d;
          busy_d = 1'b0;
        end
        if (rst || (ZERO_REG != 0 && rs_addr[gi] == '0)) begin
          data_d = '0;
          busy_d = 1'b0;
        end
      end

      assign rs_data[gi] = data_d;
      assign rs_busy[gi] = busy_d;
    end
  endgenerate

  rf_scoreboard #(
    .ADDR     (ADDR),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .clr_en    (r_write),
    .clr_addr  (rd_addr),
    .look_addr (rs_addr),
    .look_busy (look_busy),
    .busy_cnt  (busy_cnt)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp (2 write ports, bypass, zero reg).
module tb_register_file_mp;

  localparam int ADDR   = 5;
  localparam int BUS_W  = 32;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int DEPTH  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst;
  logic [NUM_WR-1:0]             r_write;
  logic [NUM_WR-1:0][ADDR-1:0]   rd_addr;
  logic [NUM_WR-1:0][BUS_W-1:0]  rd_w_data;
  logic [NUM_RD-1:0][ADDR-1:0]   rs_addr;
  logic [NUM_RD-1:0][BUS_W-1:0]  rs_data;
  logic [NUM_RD-1:0]             rs_busy;
  logic                          rsv_en;
  logic [ADDR-1:0]               rsv_addr;
  logic [ADDR:0]                 busy_cnt;

  register_file_mp #(
    .ADDR(ADDR), .BUS_W(BUS_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
    .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .r_write(r_write), .rd_addr(rd_addr),
    .rd_w_data(rd_w_data), .rs_addr(rs_addr), .rs_data(rs_data),
    .rs_busy(rs_busy), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_cnt(busy_cnt)
  );

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        busy;
    logic [5:0]  cnt;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          txn      = 0;
  logic [31:0] m_mem  [DEPTH];
  bit          m_busy [DEPTH];

  function automatic void idle();
    r_write   = '0;
    rd_addr   = '0;
    rd_w_data = '0;
    rs_addr   = '0;
    rsv_en    = 1'b0;
    rsv_addr  = '0;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  // Predict outputs for the inputs currently driven, hand them to the
  // monitor, then apply the clock edge to the reference state.
  task automatic step(input string tag);
    exp_t e;
    int   cnt;
    int   a;
    int   win;
    cnt = 0;
    for (int i = 0; i < DEPTH; i++) cnt += int'(m_busy[i]);
    for (int r = 0; r < NUM_RD; r++) begin
      a      = int'(rs_addr[r]);
      e.port = r;
      e.tag  = tag;
      e.cnt  = 6'(cnt);
      win    = -1;
      for (int w = NUM_WR - 1; w >= 0; w--) begin
        if (win < 0 && r_write[w] && int'(rd_addr[w]) == a) win = w;
      end
      if (a == 0) begin
        e.data = '0;
        e.busy = 1'b0;
      end else if (win >= 0) begin
        e.data = rd_w_data[win];
        e.busy = 1'b0;
      end else begin
        e.data = m_mem[a];
        e.busy = m_busy[a];
      end
      exp_q.push_back(e);
    end
    $display("txn %0d %s we=%b wa=%0d/%0d wd=%h/%h ra=%0d/%0d rsv=%b@%0d",
             txn, tag, r_write, rd_addr[0], rd_addr[1], rd_w_data[0],
             rd_w_data[1], rs_addr[0], rs_addr[1], rsv_en, rsv_addr);
    txn++;
    @(posedge clk);
    for (int w = NUM_WR - 1; w >= 0; w--) begin
      if (r_write[w] && rd_addr[w] != 0) begin
        win = 0;
        for (int v = w + 1; v < NUM_WR; v++)
          if (r_write[v] && rd_addr[v] == rd_addr[w]) win = 1;
        if (win == 0) m_mem[rd_addr[w]] = rd_w_data[w];
      end
    end
    for (int w = 0; w < NUM_WR; w++) if (r_write[w]) m_busy[rd_addr[w]] = 1'b0;
    if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    #1;
    idle();
  endtask

  // Monitor: compare every pending expectation at the falling edge.
  always @(negedge clk) begin : mon
    exp_t m;
    while (exp_q.size() > 0) begin
      m = exp_q.pop_front();
      checks++;
      if (rs_data[m.port] !== m.data) begin
        failures++;
        $display("FAIL %s rs_data[%0d] got=%h exp=%h", m.tag, m.port, rs_data[m.port], m.data);
      end
      checks++;
      if (rs_busy[m.port] !== m.busy) begin
        failures++;
        $display("FAIL %s rs_busy[%0d] got=%b exp=%b", m.tag, m.port, rs_busy[m.port], m.busy);
      end
      checks++;
      if (busy_cnt !== m.cnt) begin
        failures++;
        $display("FAIL %s busy_cnt got=%0d exp=%0d", m.tag, busy_cnt, m.cnt);
      end
    end
  end

  initial begin
    exp_t z;
    rst = 1'b1;
    idle();
    model_clear();
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    rs_addr[0] = 5'd5; rs_addr[1] = 5'd31;
    step("reset_state");

    r_write = 2'b01; rd_addr[0] = 5'd5; rd_w_data[0] = 32'hDEAD_BEEF;
    rs_addr[0] = 5'd5; rs_addr[1] = 5'd6;
    step("bypass_r5");
    rs_addr[0] = 5'd5;
    step("stored_r5");

    r_write = 2'b11; rd_addr[0] = 5'd7; rd_addr[1] = 5'd7;
    rd_w_data[0] = 32'h11; rd_w_data[1] = 32'h22; rs_addr[0] = 5'd7;
    step("dual_write_r7");
    rs_addr[0] = 5'd7;
    step("stored_r7");

    r_write = 2'b01; rd_addr[0] = 5'd0; rd_w_data[0] = 32'hFFFF_FFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    step("zero_write");
    step("zero_after");

    rsv_en = 1'b1; rsv_addr = 5'd3;
    step("rsv_r3");
    rsv_en = 1'b1; rsv_addr = 5'd4; rs_addr[0] = 5'd3;
    step("rsv_r4");
    rs_addr[0] = 5'd3; rs_addr[1] = 5'd4;
    step("busy_two");
    r_write = 2'b01; rd_addr[0] = 5'd3; rd_w_data[0] = 32'h33;
    rs_addr[0] = 5'd3; rs_addr[1] = 5'd4;
    step("write_r3");
    rsv_en = 1'b1; rsv_addr = 5'd4; r_write = 2'b01; rd_addr[0] = 5'd4;
    rd_w_data[0] = 32'h44; rs_addr[0] = 5'd4; rs_addr[1] = 5'd3;
    step("rsv_write_r4");
    rs_addr[0] = 5'd4; rs_addr[1] = 5'd3;
    step("busy_after");

    for (int k = 0; k < 300; k++) begin
      r_write = 2'($urandom);
      for (int w = 0; w < NUM_WR; w++) begin
        rd_addr[w]   = 5'($urandom_range(0, (k % 4 == 0) ? 31 : 7));
        rd_w_data[w] = $urandom;
      end
      for (int r = 0; r < NUM_RD; r++) rs_addr[r] = 5'($urandom_range(0, (k % 3 == 0) ? 31 : 7));
      rsv_en   = 1'($urandom);
      rsv_addr = 5'($urandom_range(0, 7));
      step("rand");
    end

    for (int i = 0; i < DEPTH; i++) begin
      r_write = 2'b11;
      rd_addr[0] = 5'(i); rd_addr[1] = 5'(i);
      rd_w_data[0] = 32'(i); rd_w_data[1] = 32'(i);
      rs_addr[0] = 5'(i); rs_addr[1] = 5'(i);
      step("sweep_wr");
    end
    for (int i = 0; i < DEPTH; i++) begin
      rs_addr[0] = 5'(i); rs_addr[1] = 5'(DEPTH - 1 - i);
      step("sweep_rd");
    end

    rsv_en = 1'b1; rsv_addr = 5'd9;
    step("pre_rst_rsv");

    // Asynchronous reset with conflicting writes and a reservation pending.
    rst = 1'b1;
    r_write = 2'b11; rd_addr[0] = 5'd5; rd_addr[1] = 5'd9;
    rd_w_data[0] = $urandom; rd_w_data[1] = $urandom;
    rs_addr[0] = 5'd5; rs_addr[1] = 5'd9; rsv_en = 1'b1; rsv_addr = 5'd9;
    for (int r = 0; r < NUM_RD; r++) begin
      z.port = r; z.data = '0; z.busy = 1'b0; z.cnt = '0; z.tag = "mid_reset";
      exp_q.push_back(z);
    end
    $display("txn %0d mid_reset rst=1 ra=5/9", txn);
    txn++;
    @(negedge clk);
    #1;
    rst = 1'b0;
    idle();
    model_clear();
    @(posedge clk);
    #1;

    for (int i = 0; i < DEPTH; i++) begin
      rs_addr[0] = 5'(i); rs_addr[1] = 5'(DEPTH - 1 - i);
      step("post_rst");
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
